// File: rtl/led_arbiter.sv
// led_arbiter: arbitrates LED ownership between a bouncing scanner, the Nios PIO
// and a debounced push-button override window. Optional macro: LED_ARBITER_PRESS_COUNT_EN.
// Ports: CLK12M, RST_BTN (sync, active-low), USER_BTN (raw, low = pressed),
//        cpu_req, cpu_leds[7:0] in; btn_level, LED[7:0], owner[1:0] out
//        (owner 00 scan, 01 cpu, 10 override); press_cnt[7:0] out with the macro.
module led_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned SCAN_DIV        = 1200000,
  parameter int unsigned OVR_CYCLES      = 36000000
) (
  input  logic       CLK12M,
  input  logic       RST_BTN,
  input  logic       USER_BTN,
  input  logic       cpu_req,
  input  logic [7:0] cpu_leds,
  output logic       btn_level,
  output logic [7:0] LED,
  output logic [1:0] owner
`ifdef LED_ARBITER_PRESS_COUNT_EN
  ,
  output logic [7:0] press_cnt
`endif
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int OW = $clog2(OVR_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SD_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [OW-1:0] OVR_LOAD = OW'(OVR_CYCLES);

  typedef enum logic [1:0] {
    ST_SCAN = 2'b00,
    ST_CPU  = 2'b01,
    ST_OVR  = 2'b10
  } state_e;

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          btn_now;
  logic          press;

  logic [SW-1:0] div_q, div_d;
  logic [7:0]    pos_q, pos_d;
  logic          up_q, up_d;

  state_e        state_q, state_d;
  logic [OW-1:0] ovr_q, ovr_d;
  logic [7:0]    led_q, led_d;

`ifdef LED_ARBITER_PRESS_COUNT_EN
  logic [7:0]    pc_q, pc_d;
`endif

  assign btn_now = ~sync_q[1];

  // Press pulses on the same cycle the stable value flips to pressed.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (btn_now != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = btn_now;
        press    = btn_now;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    div_d = div_q;
    pos_d = pos_q;
    up_d  = up_q;
    if (state_q != ST_CPU) begin
      if (div_q == SD_LAST) begin
        div_d = '0;
        if (up_q) begin
          if (pos_q[7]) begin
            pos_d = 8'h40;
            up_d  = 1'b0;
          end else begin
            pos_d = pos_q << 1;
          end
        end else begin
          if (pos_q[0]) begin
            pos_d = 8'h02;
            up_d  = 1'b1;
          end else begin
            pos_d = pos_q >> 1;
          end
        end
      end else begin
        div_d = div_q + SW'(1);
      end
    end
  end

  // Window ends on the cycle the counter would reach zero,
  // so OVERRIDE lasts exactly OVR_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      ST_SCAN: begin
        if (press) begin
          state_d = ST_OVR;
          ovr_d   = OVR_LOAD;
        end else if (cpu_req) begin
          state_d = ST_CPU;
        end
      end
      ST_CPU: begin
        if (press) begin
          state_d = ST_OVR;
          ovr_d   = OVR_LOAD;
        end else if (!cpu_req) begin
          state_d = ST_SCAN;
        end
      end
      ST_OVR: begin
        if (press) begin
          ovr_d = OVR_LOAD;
        end else if (ovr_q <= OW'(1)) begin
          ovr_d   = '0;
          state_d = cpu_req ? ST_CPU : ST_SCAN;
        end else begin
          ovr_d = ovr_q - OW'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        ovr_d   = '0;
      end
    endcase
  end

  always_comb begin
    led_d = pos_q;
    unique case (state_q)
      ST_CPU:  led_d = cpu_leds;
`ifdef LED_ARBITER_PRESS_COUNT_EN
      ST_OVR:  led_d = pc_q;
`endif
      default: led_d = pos_q;
    endcase
  end

`ifdef LED_ARBITER_PRESS_COUNT_EN
  always_comb begin
    pc_d = pc_q;
    if (press) pc_d = pc_q + 8'd1;
  end
`endif

  always_ff @(posedge CLK12M) begin
    if (!RST_BTN) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      div_q    <= '0;
      pos_q    <= 8'h01;
      up_q     <= 1'b1;
      state_q  <= ST_SCAN;
      ovr_q    <= '0;
      led_q    <= 8'h00;
`ifdef LED_ARBITER_PRESS_COUNT_EN
      pc_q     <= 8'h00;
`endif
    end else begin
      sync_q   <= {sync_q[0], USER_BTN};
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      div_q    <= div_d;
      pos_q    <= pos_d;
      up_q     <= up_d;
      state_q  <= state_d;
      ovr_q    <= ovr_d;
      led_q    <= led_d;
`ifdef LED_ARBITER_PRESS_COUNT_EN
      pc_q     <= pc_d;
`endif
    end
  end

  assign btn_level = stable_q;
  assign LED       = led_q;
  assign owner     = state_q;
`ifdef LED_ARBITER_PRESS_COUNT_EN
  assign press_cnt = pc_q;
`endif

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: scoreboard bench for led_arbiter with small parameters.
// A cycle model pushes expected outputs at each posedge; tasks pop and compare.
module tb_led_arbiter;

  localparam int DB = 4;
  localparam int SD = 3;
  localparam int OC = 10;
`ifdef LED_ARBITER_PRESS_COUNT_EN
  localparam bit PCEN = 1'b1;
`else
  localparam bit PCEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ubtn = 1'b1;
  logic       creq = 1'b0;
  logic [7:0] cled = 8'h00;
  logic       btn_level;
  logic [7:0] led;
  logic [1:0] owner;
  logic [7:0] pc_act;

  always #5 clk = ~clk;

`ifdef LED_ARBITER_PRESS_COUNT_EN
  logic [7:0] press_cnt;
  assign pc_act = press_cnt;
`else
  assign pc_act = 8'h00;
`endif

  led_arbiter #(
    .DEBOUNCE_CYCLES(DB),
    .SCAN_DIV(SD),
    .OVR_CYCLES(OC)
  ) dut (
    .CLK12M(clk),
    .RST_BTN(rst_n),
    .USER_BTN(ubtn),
    .cpu_req(creq),
    .cpu_leds(cled),
    .btn_level(btn_level),
    .LED(led),
    .owner(owner)
`ifdef LED_ARBITER_PRESS_COUNT_EN
    ,
    .press_cnt(press_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] led;
    logic       btn;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic       m_s0, m_s1, m_stab;
  logic [1:0] m_st;
  logic [7:0] m_led, m_pc;
  int         m_dbc, m_div, m_ph, m_ovr;

  // Bounce phase 0..13 -> one-hot: 01..80 then 40..02.
  function automatic logic [7:0] pat(input int ph);
    logic [7:0] one;
    one = 8'h01;
    pat = (ph < 8) ? (one << ph) : (one << (14 - ph));
  endfunction

  always @(posedge clk) begin : model
    logic nb, pr;
    if (!rst_n) begin
      m_s0 = 1'b1; m_s1 = 1'b1; m_stab = 1'b0;
      m_dbc = 0; m_div = 0; m_ph = 0; m_ovr = 0;
      m_st = 2'b00; m_led = 8'h00; m_pc = 8'h00;
    end else begin
      if (m_st == 2'b01) m_led = cled;
      else if (m_st == 2'b10 && PCEN) m_led = m_pc;
      else m_led = pat(m_ph);
      if (m_st != 2'b01) begin
        m_div++;
        if (m_div == SD) begin
          m_div = 0;
          m_ph = (m_ph + 1) % 14;
        end
      end
      nb = ~m_s1;
      pr = 1'b0;
      if (nb != m_stab) begin
        m_dbc++;
        if (m_dbc == DB) begin
          m_dbc = 0;
          m_stab = nb;
          pr = nb;
        end
      end else begin
        m_dbc = 0;
      end
      m_s1 = m_s0;
      m_s0 = ubtn;
      case (m_st)
        2'b00: if (pr) begin m_st = 2'b10; m_ovr = OC; end
               else if (creq) m_st = 2'b01;
        2'b01: if (pr) begin m_st = 2'b10; m_ovr = OC; end
               else if (!creq) m_st = 2'b00;
        default: begin
          if (pr) m_ovr = OC;
          else begin
            m_ovr--;
            if (m_ovr == 0) m_st = creq ? 2'b01 : 2'b00;
          end
        end
      endcase
      if (pr && PCEN) m_pc = m_pc + 8'd1;
    end
    sb.push_back('{own: m_st, led: m_led, btn: m_stab, pc: m_pc});
  end

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; ubtn = 1'b1; creq = 1'b0; cled = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL reset_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      checks++;
      if ({owner, led, btn_level} !== 11'h000) begin
        errors++;
        $display("FAIL reset_state got own=%b led=%h btn=%b want 00/00/0",
                 owner, led, btn_level);
      end
    end
  endtask

  task automatic test_scan();
    exp_t e;
    int first02 = -1;
    bit seen80 = 0, bounce = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL scan_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (c == 0) begin
        checks++;
        if (led !== 8'h01) begin
          errors++;
          $display("FAIL scan_first got %h want 01", led);
        end
      end
      if (led == 8'h02 && first02 < 0) first02 = c;
      if (led == 8'h80) seen80 = 1;
      if (seen80 && led == 8'h40) bounce = 1;
    end
    checks++;
    if (first02 != 3) begin
      errors++;
      $display("FAIL scan_step got cycle %0d want 3", first02);
    end
    checks++;
    if (!bounce) begin
      errors++;
      $display("FAIL scan_bounce got no 80->40 want bounce");
    end
  endtask

  task automatic test_debounce();
    exp_t e;
    bit bad = 0;
    int rise = -1;
    for (int c = 0; c < 15; c++) begin
      ubtn = (c < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL glitch_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (btn_level !== 1'b0 || owner === 2'b10) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL glitch_reject got btn/override change want none");
    end
    for (int c = 0; c < 40; c++) begin
      ubtn = (c < 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL press_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (btn_level === 1'b1 && rise < 0) rise = c;
      if (c == 5) begin
        checks++;
        if (owner !== 2'b10) begin
          errors++;
          $display("FAIL press_owner got %b want 10", owner);
        end
      end
    end
    checks++;
    if (rise != 5) begin
      errors++;
      $display("FAIL press_latency got cycle %0d want 5", rise);
    end
  endtask

  task automatic test_cpu();
    exp_t e;
    for (int c = 0; c < 30; c++) begin
      creq = (c < 14);
      cled = (c < 8) ? 8'hA5 : 8'h5A;
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL cpu_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (c == 0 || c == 14) begin
        checks++;
        if (owner !== ((c == 0) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL cpu_owner c=%0d got %b", c, owner);
        end
      end
      if (c == 1 || c == 8) begin
        checks++;
        if (led !== ((c == 1) ? 8'hA5 : 8'h5A)) begin
          errors++;
          $display("FAIL cpu_led c=%0d got %h", c, led);
        end
      end
    end
  endtask

  task automatic test_override();
    exp_t e;
    int n1 = 0, n2 = 0;
    creq = 1'b1; cled = 8'h3C;
    for (int c = 0; c < 30; c++) begin
      ubtn = (c >= 5 && c < 9) ? 1'b0 : 1'b1;
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL ovr1_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (owner === 2'b10) n1++;
    end
    checks++;
    if (n1 != OC) begin
      errors++;
      $display("FAIL ovr_window got %0d want %0d", n1, OC);
    end
    for (int c = 0; c < 35; c++) begin
      ubtn = (c < 4 || (c >= 8 && c < 12)) ? 1'b0 : 1'b1;
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL ovr2_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (owner === 2'b10) n2++;
      if (c == 23) begin
        checks++;
        if (owner !== 2'b01) begin
          errors++;
          $display("FAIL ovr_exit got %b want 01", owner);
        end
      end
      if (c == 24) begin
        checks++;
        if (led !== 8'h3C) begin
          errors++;
          $display("FAIL ovr_cpu_led got %h want 3c", led);
        end
      end
    end
    checks++;
    if (n2 != 18) begin
      errors++;
      $display("FAIL ovr_extend got %0d want 18", n2);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    creq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      ubtn = (c < 4) ? 1'b0 : 1'b1;
      rst_n = !(c == 7 || c == 8);
      @(negedge clk);
      e = sb.pop_front(); checks++;
      if ({owner, led, btn_level, pc_act} !== e) begin
        errors++;
        $display("FAIL rstmid_sb c=%0d got %h want %h", c,
                 {owner, led, btn_level, pc_act}, e);
      end
      if (c == 7) begin
        checks++;
        if ({owner, led, pc_act} !== 18'h0) begin
          errors++;
          $display("FAIL rstmid_clear got own=%b led=%h pc=%h want 0",
                   owner, led, pc_act);
        end
      end
      if (c == 9) begin
        checks++;
        if (led !== 8'h01) begin
          errors++;
          $display("FAIL rstmid_led got %h want 01", led);
        end
      end
    end
  endtask

`ifdef LED_ARBITER_PRESS_COUNT_EN
  task automatic test_press_count();
    exp_t e;
    logic [7:0] want;
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 12; c++) begin
        ubtn = (c < 4) ? 1'b0 : 1'b1;
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if ({owner, led, btn_level, pc_act} !== e) begin
          errors++;
          $display("FAIL pc_sb i=%0d c=%0d got %h want %h", i, c,
                   {owner, led, btn_level, pc_act}, e);
        end
        if (c == 6 && (i % 64) == 3) begin
          want = 8'(i + 1);
          checks++;
          if (led !== want) begin
            errors++;
            $display("FAIL pc_led i=%0d got %h want %h", i, led, want);
          end
        end
      end
    end
    checks++;
    if (press_cnt !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap got %h want 00", press_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_debounce();
    test_cpu();
    test_override();
    test_reset_mid();
`ifdef LED_ARBITER_PRESS_COUNT_EN
    test_press_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
